instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 127 ++++++++++++
 tb/tb_instruction_fetch.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - two-stage instruction fetch with branch, halt and stall handling
module instruction_fetch #(
    parameter int         PC_W      = 10,
    parameter logic [8:0] NOP_INSTR = 9'b110110000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [PC_W-1:0] start_addr,
    input  logic            halt,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_data,
    output logic [8:0]      instruction_out,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc_out,
    output logic            running,
    output logic            done,
    output logic [15:0]     cycle_count
);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            s1_v_q, s1_v_d;
    logic [PC_W-1:0] tag_q, tag_d;
    logic            hold_q, hold_d;
    logic [8:0]      s1_data_q, s1_data_d;
    logic [8:0]      instr_q, instr_d;
    logic            valid_q, valid_d;
    logic [PC_W-1:0] pc_out_q, pc_out_d;
    logic [15:0]     cycle_q, cycle_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        s1_v_d    = s1_v_q;
        tag_d     = tag_q;
        hold_d    = hold_q;
        s1_data_d = s1_data_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        pc_out_d  = pc_out_q;
        cycle_d   = cycle_q;
        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = start_addr;
                    s1_v_d  = 1'b0;
                    hold_d  = 1'b0;
                    cycle_d = 16'd0;
                end
            end
            RUN: begin
                cycle_d = (cycle_q == 16'hFFFF) ? cycle_q : cycle_q + 16'd1;
                if (branch_taken) begin
                    pc_d    = branch_target;
                    s1_v_d  = 1'b0;
                    hold_d  = 1'b0;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end else if (halt) begin
                    state_d = HALTED;
                    s1_v_d  = 1'b0;
                    hold_d  = 1'b0;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end else if (stall) begin
                    // The ROM keeps reading pc_q while stalled, so park the word
                    // that belongs to the stage-1 tag on the first stalled edge.
                    if (!hold_q) begin
                        hold_d    = 1'b1;
                        s1_data_d = imem_data;
                    end
                end else begin
                    pc_d     = pc_q + PC_W'(1);
                    s1_v_d   = 1'b1;
                    tag_d    = pc_q;
                    hold_d   = 1'b0;
                    valid_d  = s1_v_q;
                    pc_out_d = tag_q;
                    instr_d  = s1_v_q ? (hold_q ? s1_data_q : imem_data) : NOP_INSTR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            s1_v_q    <= 1'b0;
            tag_q     <= '0;
            hold_q    <= 1'b0;
            s1_data_q <= NOP_INSTR;
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
            pc_out_q  <= '0;
            cycle_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            s1_v_q    <= s1_v_d;
            tag_q     <= tag_d;
            hold_q    <= hold_d;
            s1_data_q <= s1_data_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            pc_out_q  <= pc_out_d;
            cycle_q   <= cycle_d;
        end
    end

    assign imem_addr       = pc_q;
    assign instruction_out = instr_q;
    assign instr_valid     = valid_q;
    assign pc_out          = pc_out_q;
    assign running         = (state_q == RUN);
    assign done            = (state_q == HALTED);
    assign cycle_count     = cycle_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed and randomized checks of instruction_fetch against a stream model
module tb_instruction_fetch;

    localparam int         PC_W = 10;
    localparam logic [8:0] NOP  = 9'b110110000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [PC_W-1:0] start_addr = '0;
    logic            halt = 1'b0;
    logic            stall = 1'b0;
    logic            branch_taken = 1'b0;
    logic [PC_W-1:0] branch_target = '0;
    logic [PC_W-1:0] imem_addr;
    logic [8:0]      imem_data = '0;
    logic [8:0]      instruction_out;
    logic            instr_valid;
    logic [PC_W-1:0] pc_out;
    logic            running;
    logic            done;
    logic [15:0]     cycle_count;

    logic [8:0] mem [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    // Stream model: after a launch or redirect to m_base, the k-th unstalled
    // RUN edge delivers address m_base + k - 2 once k >= 2.
    int m_mode = 0;
    int m_base = 0;
    int m_adv  = 0;
    int m_cc   = 0;

    instruction_fetch #(.PC_W(PC_W), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .halt(halt), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
        .instruction_out(instruction_out), .instr_valid(instr_valid), .pc_out(pc_out),
        .running(running), .done(done), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr];

    task automatic model_edge();
        if (!rst_n) begin
            m_mode = 0; m_base = 0; m_adv = 0; m_cc = 0;
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode = 1; m_base = int'(start_addr); m_adv = 0; m_cc = 0;
            end
        end else begin
            m_cc = (m_cc < 65535) ? m_cc + 1 : 65535;
            if (branch_taken) begin
                m_base = int'(branch_target); m_adv = 0;
            end else if (halt) begin
                m_mode = 2;
            end else if (!stall) begin
                m_adv++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; halt = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        step(); step();
        n_checks++;
        if ({instr_valid, running, done} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {instr_valid, running, done});
        end
        n_checks++;
        if (instruction_out !== NOP) begin
            n_fail++; $display("FAIL reset_instr: got %h want %h", instruction_out, NOP);
        end
        n_checks++;
        if (pc_out !== 10'd0 || imem_addr !== 10'd0 || cycle_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_regs: pc_out %h imem_addr %h cc %0d want 0", pc_out, imem_addr, cycle_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_launch();
        start = 1'b1; start_addr = 10'd5; stall = 1'b1;
        step();
        start = 1'b0; stall = 1'b0;
        n_checks++;
        if (running !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 10'd5) begin
            n_fail++; $display("FAIL launch_edge0: running %b valid %b addr %h want 1 0 005", running, instr_valid, imem_addr);
        end
        step();
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL launch_edge1: valid %b want 0", instr_valid);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (instr_valid !== 1'b1 || pc_out !== 10'(5 + k) || instruction_out !== 9'(5 + k)) begin
                n_fail++; $display("FAIL launch_seq%0d: valid %b pc %h instr %h want 1 %h %h", k, instr_valid, pc_out, instruction_out, 5 + k, 5 + k);
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (instr_valid !== 1'b1 || pc_out !== 10'd7 || instruction_out !== 9'd7) begin
                n_fail++; $display("FAIL stall_hold%0d: valid %b pc %h instr %h want 1 007 007", k, instr_valid, pc_out, instruction_out);
            end
        end
        stall = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++;
            if (instr_valid !== 1'b1 || pc_out !== 10'(8 + k) || instruction_out !== 9'(8 + k)) begin
                n_fail++; $display("FAIL stall_release%0d: valid %b pc %h instr %h want 1 %h %h", k, instr_valid, pc_out, instruction_out, 8 + k, 8 + k);
            end
        end
    endtask

    task automatic test_branch_wrap();
        logic [PC_W-1:0] exp_pc;
        branch_taken = 1'b1; branch_target = 10'h3FE; stall = 1'b1;
        step();
        branch_taken = 1'b0; stall = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (instr_valid !== 1'b0 || instruction_out !== NOP) begin
                n_fail++; $display("FAIL branch_bubble%0d: valid %b instr %h want 0 %h", k, instr_valid, instruction_out, NOP);
            end
            step();
        end
        for (int k = 0; k < 3; k++) begin
            exp_pc = 10'(10'h3FE + k);
            n_checks++;
            if (instr_valid !== 1'b1 || pc_out !== exp_pc || instruction_out !== mem[exp_pc]) begin
                n_fail++; $display("FAIL branch_wrap%0d: valid %b pc %h instr %h want 1 %h %h", k, instr_valid, pc_out, instruction_out, exp_pc, mem[exp_pc]);
            end
            step();
        end
    endtask

    task automatic test_halt_priority();
        logic [15:0]     frozen_cc;
        logic [PC_W-1:0] frozen_addr;
        halt = 1'b1; branch_taken = 1'b1; branch_target = 10'h100;
        step();
        halt = 1'b0; branch_taken = 1'b0;
        n_checks++;
        if (running !== 1'b1 || done !== 1'b0 || imem_addr !== 10'h100) begin
            n_fail++; $display("FAIL halt_vs_branch: running %b done %b addr %h want 1 0 100", running, done, imem_addr);
        end
        step(); step();
        n_checks++;
        if (instr_valid !== 1'b1 || pc_out !== 10'h100) begin
            n_fail++; $display("FAIL branch_after_tie: valid %b pc %h want 1 100", instr_valid, pc_out);
        end
        halt = 1'b1;
        step();
        halt = 1'b0;
        frozen_cc = cycle_count;
        frozen_addr = imem_addr;
        n_checks++;
        if (done !== 1'b1 || running !== 1'b0 || instr_valid !== 1'b0 || instruction_out !== NOP) begin
            n_fail++; $display("FAIL halt_state: done %b running %b valid %b instr %h want 1 0 0 %h", done, running, instr_valid, instruction_out, NOP);
        end
        n_checks++;
        if (cycle_count !== 16'(m_cc)) begin
            n_fail++; $display("FAIL halt_cycles: got %0d want %0d", cycle_count, m_cc);
        end
        stall = 1'b1;
        step(); step(); step();
        stall = 1'b0;
        n_checks++;
        if (cycle_count !== frozen_cc || imem_addr !== frozen_addr || instr_valid !== 1'b0 || done !== 1'b1) begin
            n_fail++; $display("FAIL halted_frozen: cc %0d addr %h valid %b done %b want %0d %h 0 1", cycle_count, imem_addr, instr_valid, done, frozen_cc, frozen_addr);
        end
    endtask

    task automatic test_restart();
        start = 1'b1; start_addr = 10'h020;
        step();
        start = 1'b0;
        n_checks++;
        if (cycle_count !== 16'd0 || running !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL restart_edge: cc %0d running %b done %b want 0 1 0", cycle_count, running, done);
        end
        step(); step();
        n_checks++;
        if (instr_valid !== 1'b1 || pc_out !== 10'h020 || cycle_count !== 16'd2) begin
            n_fail++; $display("FAIL restart_first: valid %b pc %h cc %0d want 1 020 2", instr_valid, pc_out, cycle_count);
        end
    endtask

    task automatic test_reset_mid_stall();
        stall = 1'b1;
        step();
        rst_n = 1'b0; start = 1'b1; start_addr = 10'h055;
        step();
        n_checks++;
        if ({running, done, instr_valid} !== 3'b000 || instruction_out !== NOP || pc_out !== 10'd0
            || imem_addr !== 10'd0 || cycle_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_in_stall: r%b d%b v%b instr %h pc %h addr %h cc %0d want all reset", running, done, instr_valid, instruction_out, pc_out, imem_addr, cycle_count);
        end
        rst_n = 1'b1; start = 1'b0; stall = 1'b0;
        step();
        n_checks++;
        if (running !== 1'b0 || imem_addr !== 10'd0) begin
            n_fail++; $display("FAIL start_during_reset: running %b addr %h want 0 000", running, imem_addr);
        end
    endtask

    task automatic test_random();
        int exp_pc;
        bit exp_valid;
        for (int i = 0; i < 1024; i++) mem[i] = 9'($urandom);
        rst_n = 1'b0;
        idle_inputs();
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst_n         = ($urandom_range(0, 299) != 0);
            start         = ($urandom_range(0, 15) == 0);
            start_addr    = 10'($urandom);
            halt          = ($urandom_range(0, 40) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 12) == 0);
            branch_target = 10'($urandom);
            step();
            exp_valid = (m_mode == 1) && (m_adv >= 2);
            exp_pc    = (m_base + m_adv - 2) % 1024;
            n_checks++;
            if (instr_valid !== exp_valid || running !== (m_mode == 1) || done !== (m_mode == 2)) begin
                n_fail++; $display("FAIL rand_ctrl@%0d: v%b r%b d%b want v%b r%b d%b", i, instr_valid, running, done, exp_valid, m_mode == 1, m_mode == 2);
            end
            n_checks++;
            if (imem_addr !== 10'((m_base + m_adv) % 1024) || cycle_count !== 16'(m_cc)) begin
                n_fail++; $display("FAIL rand_addr_cc@%0d: addr %h cc %0d want %h %0d", i, imem_addr, cycle_count, (m_base + m_adv) % 1024, m_cc);
            end
            n_checks++;
            if (exp_valid && (pc_out !== 10'(exp_pc) || instruction_out !== mem[exp_pc])) begin
                n_fail++; $display("FAIL rand_data@%0d: pc %h instr %h want %h %h", i, pc_out, instruction_out, exp_pc, mem[exp_pc]);
            end else if (!exp_valid && instruction_out !== NOP) begin
                n_fail++; $display("FAIL rand_bubble@%0d: instr %h want %h", i, instruction_out, NOP);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 9'(i);
        test_reset();
        test_launch();
        test_stall();
        test_branch_wrap();
        test_halt_priority();
        test_restart();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
